serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised bit-serial adder. It reuses one full-adder cell and a carry flip-flop to add two WIDTH-bit operands, one bit per clock, LSB first.
- Successor to the single-bit structural full adder. It adds operand width, a carry chain through time, valid/ready handshakes and signed-overflow detection.
- Intended for area-constrained datapaths where an N-bit add may take N cycles.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- cin  input  1  carry-in.
- out_valid  output  1  sum, cout and ovf are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - Operand shift registers, sum register, carry register, msb-carry register and counter all cleared to 0.
  - sum=0, cout=0, ovf=0, out_valid=0, in_ready=1.
  - Reset asserted in any state, including mid-RUN, aborts the operation with no output produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid && in_ready: load a and b into shift registers, carry<=cin, cnt<=0, go to RUN.
  - Operands are sampled only on that edge; later changes to a, b and cin are ignored.
- RUN, each cycle:
  - s = A0^B0^carry; c = majority(A0,B0,carry).
  - Shift A and B right by 1.
  - Shift s into the sum register at the MSB, shifting right.
  - carry<=c; cnt<=cnt+1.
  - On the cycle where cnt==WIDTH-1, also capture the carry-in to the MSB (the old carry) into msb_c.
  - After WIDTH RUN cycles, go to DONE.
- DONE:
  - out_valid=1; sum holds the full result, LSB-aligned.
  - cout=carry; ovf=msb_c^carry.
  - Outputs are stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE; sum, cout and ovf keep their values (not cleared).
- Latency: the input handshake is on edge E0; out_valid rises after edge E0+WIDTH. With out_ready tied high, throughput is one add per WIDTH+2 cycles.
- in_ready is 0 throughout RUN and DONE. in_valid asserted there is not accepted, and no state changes.
- Arithmetic is modulo 2^WIDTH; overflow is reported only via cout and ovf.
- in_ready and out_valid are decoded from state registers only. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands at the input handshake.
  - When sub=1, B is loaded inverted and carry is initialised to ~cin. With cin=0 this gives A-B.
  - cout=1 means no borrow; ovf is the signed overflow of the subtraction.
- Undefined:
  - No sub port; the block is add-only.
  - Logic is identical to the defined case with sub=0.

Test Plan:
- Reset with rst_n=0 for 3 cycles, then release:
  - Required during and after reset: in_ready=1, out_valid=0, sum=0x00, cout=0, ovf=0.
- WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1:
  - out_valid rises exactly 8 cycles after the handshake.
  - sum=0x96, cout=0, ovf=1.
  - in_ready returns to 1 one cycle after the output handshake.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
- a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Backpressure on a=0x12, b=0x34, cin=0: hold out_ready=0 for 5 cycles after out_valid rises.
  - sum=0x46 stays stable, out_valid stays 1, in_ready stays 0.
  - in_valid pulses with new operands during this window are ignored.
- Reset mid-operation: assert rst_n=0 at RUN cycle 3.
  - Immediately: out_valid=0, in_ready=1, sum=0.
  - A new add after release, 0x01+0x01, yields 0x02.
- With SERIAL_ADDER_SUB_EN, run the following; also run random 1000-vector self-check against a+b+cin for WIDTH=8 and WIDTH=3:
  - sub=1, a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0.
  - a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop adds two WIDTH-bit operands LSB first.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port for two's-complement subtraction.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // valid must hold its payload until that edge, and ready never depends on valid.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic             msb_c;
   logic [CNT_W-1:0] cnt;
   logic             sub_w;
   logic             bit_s;
   logic             bit_c;
   logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_w = sub;
`else
   assign sub_w = 1'b0;
`endif

   assign bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
   assign bit_c    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         msb_c  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is A + ~B + ~cin, so the carry seed flips with sub.
                  a_sr  <= a;
                  b_sr  <= sub_w ? ~b : b;
                  carry <= cin ^ sub_w;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
               carry  <= bit_c;
               cnt    <= cnt + CNT_W'(1);
               if (last_bit) msb_c <= carry;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_sr;
   assign cout      = carry;
   assign ovf       = msb_c ^ carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed vectors plus random add vectors at WIDTH=8 and WIDTH=3.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, sum;
   logic       cin, cout, ovf, sub;

   logic       in_valid3, in_ready3, out_valid3, out_ready3;
   logic [2:0] a3, b3, sum3;
   logic       cin3, cout3, ovf3, sub3;

   int checks = 0;
   int errors = 0;

   // Expected results packed as {ovf, cout, sum}.
   logic [9:0] exp_q[$];
   logic [4:0] exp3_q[$];
   logic [9:0] exp_e;
   logic [4:0] exp3_e;

   serial_adder #(.WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   serial_adder #(.WIDTH(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
      .a(a3), .b(b3), .cin(cin3),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub3),
`endif
      .out_valid(out_valid3), .out_ready(out_ready3), .sum(sum3), .cout(cout3), .ovf(ovf3)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
      end
   endfunction

   function automatic logic [9:0] model8(logic [7:0] x, logic [7:0] y, logic c);
      logic [8:0] t;
      t = {1'b0, x} + {1'b0, y} + {8'b0, c};
      return {(x[7] == y[7]) && (t[7] != x[7]), t[8], t[7:0]};
   endfunction

   function automatic logic [4:0] model3(logic [2:0] x, logic [2:0] y, logic c);
      logic [3:0] t;
      t = {1'b0, x} + {1'b0, y} + {3'b0, c};
      return {(x[2] == y[2]) && (t[2] != x[2]), t[3], t[2:0]};
   endfunction

   // driver tasks
   task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic sv, input logic [9:0] ev, input bit push);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("send8_in_ready_timeout", 64'(in_ready), 64'd1);
      a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
      if (push) exp_q.push_back(ev);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send3(input logic [2:0] av, input logic [2:0] bv, input logic cv);
      int n;
      n = 0;
      while (!in_ready3 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready3) chk("send3_in_ready_timeout", 64'(in_ready3), 64'd1);
      a3 = av; b3 = bv; cin3 = cv; in_valid3 = 1'b1;
      exp3_q.push_back(model3(av, bv, cv));
      @(posedge clk); #1;
      in_valid3 = 1'b0;
   endtask

   task automatic wait_valid8(output int k);
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!out_valid && k < 100);
   endtask

   task automatic add_and_check(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                                input logic sv, input logic [9:0] ev, input string nm);
      int k;
      send8(av, bv, cv, sv, ev, 1'b1);
      wait_valid8(k);
      chk({nm, "_latency"}, 64'(k), 64'd8);
      @(posedge clk); #1;
      chk({nm, "_in_ready_after"}, 64'(in_ready), 64'd1);
      chk({nm, "_out_valid_after"}, 64'(out_valid), 64'd0);
   endtask

   // scoreboard monitors
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("w8_unexpected_output", {54'b0, ovf, cout, sum}, 64'h3ff_ffff);
         end else begin
            exp_e = exp_q.pop_front();
            chk("w8_result", {54'b0, ovf, cout, sum}, {54'b0, exp_e});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid3 && out_ready3) begin
         if (exp3_q.size() == 0) begin
            chk("w3_unexpected_output", {59'b0, ovf3, cout3, sum3}, 64'h3ff_ffff);
         end else begin
            exp3_e = exp3_q.pop_front();
            chk("w3_result", {59'b0, ovf3, cout3, sum3}, {59'b0, exp3_e});
         end
      end
   end

   // main sequence
   initial begin
      int k;
      int n;
      logic [7:0] av, bv;
      logic [2:0] a3v, b3v;
      logic       cv;

      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      in_valid3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0; sub3 = 1'b0; out_ready3 = 1'b1;

      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", 64'(sum), 64'h00);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
      chk("post_rst_sum", 64'(sum), 64'h00);
      chk("post_rst_cout_ovf", {62'b0, cout, ovf}, 64'd0);

      // {ovf, cout, sum} hand-computed
      add_and_check(8'h5A, 8'h3C, 1'b0, 1'b0, {1'b1, 1'b0, 8'h96}, "add_5a_3c");
      add_and_check(8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00}, "add_ff_01");
      add_and_check(8'h7F, 8'h00, 1'b1, 1'b0, {1'b1, 1'b0, 8'h80}, "add_7f_00_c1");

      // backpressure with ignored input pulses
      out_ready = 1'b0;
      send8(8'h12, 8'h34, 1'b0, 1'b0, {1'b0, 1'b0, 8'h46}, 1'b1);
      wait_valid8(k);
      chk("bp_latency", 64'(k), 64'd8);
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_sum", 64'(sum), 64'h46);
         a = 8'hAA; b = 8'h55; cin = 1'b1;
         in_valid = (i == 1 || i == 3);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_in_ready_after", 64'(in_ready), 64'd1);
      chk("bp_sum_kept", 64'(sum), 64'h46);

      // reset in the third RUN cycle aborts the add
      send8(8'h33, 8'h44, 1'b0, 1'b0, 10'h0, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_sum", 64'(sum), 64'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      add_and_check(8'h01, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h02}, "add_after_rst");

`ifdef SERIAL_ADDER_SUB_EN
      add_and_check(8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE}, "sub_05_07");
      add_and_check(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F}, "sub_80_01");
`endif

      for (int i = 0; i < 1000; i++) begin
         av = 8'($urandom_range(0, 255));
         bv = 8'($urandom_range(0, 255));
         cv = 1'($urandom_range(0, 1));
         send8(av, bv, cv, 1'b0, model8(av, bv, cv), 1'b1);
      end

      for (int i = 0; i < 1000; i++) begin
         a3v = 3'($urandom_range(0, 7));
         b3v = 3'($urandom_range(0, 7));
         cv  = 1'($urandom_range(0, 1));
         send3(a3v, b3v, cv);
      end

      n = 0;
      while ((exp_q.size() != 0 || exp3_q.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("w8_queue_drained", 64'(exp_q.size()), 64'd0);
      chk("w3_queue_drained", 64'(exp3_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
